// File: rtl/bingo_pkg.sv
// bingo_pkg: shared arbiter state encodings, requester indices and winner selection.
package bingo_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } arb_state_t;

    localparam logic [1:0] LD = 2'd0;
    localparam logic [1:0] GL = 2'd1;
    localparam logic [1:0] DP = 2'd2;

    // Loader always wins; a gl/dp tie goes to dp only when dp_first is set.
    function automatic logic [1:0] pick_winner(input logic ld,
                                               input logic gl,
                                               input logic dp,
                                               input logic dp_first);
        logic [1:0] win;
        if (ld)
            win = LD;
        else if (gl && dp)
            win = dp_first ? DP : GL;
        else if (gl)
            win = GL;
        else
            win = DP;
        return win;
    endfunction

endpackage

// File: rtl/card_ram_arbiter_cnt.sv
// card_ram_arbiter_cnt: saturating burst counter (clear to 0, load to 1, count up to MAX).
module card_ram_arbiter_cnt #(
    parameter int WIDTH = 3,
    parameter int MAX   = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic load,
    input  logic inc,
    output logic at_max
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] count_q;

    // Count granted cycles; holds at MAX so a lone owner can keep the grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count_q <= '0;
        else if (clr)
            count_q <= '0;
        else if (load)
            count_q <= WIDTH'(1);
        else if (inc && (count_q != MAX_V))
            count_q <= count_q + WIDTH'(1);
    end

    assign at_max = (count_q == MAX_V);

endmodule

// File: rtl/card_ram_arbiter.sv
// card_ram_arbiter: three-way card RAM arbiter (loader, game logic, display scanner).
// Build macro CARD_ARB_RR_EN: gl and dp share round-robin; without it gl always beats dp.
//
// state | meaning
// IDLE  | no grant active, waiting for any request
// HOLD  | one requester owns the RAM; burst counter tracks its granted cycles
module card_ram_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int BURST_MAX  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ld_req,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_wdata,
    output logic                  ld_gnt,
    input  logic                  gl_req,
    input  logic                  gl_we,
    input  logic [ADDR_WIDTH-1:0] gl_addr,
    input  logic [DATA_WIDTH-1:0] gl_wdata,
    output logic                  gl_gnt,
    output logic                  gl_rvalid,
    input  logic                  dp_req,
    input  logic [ADDR_WIDTH-1:0] dp_addr,
    output logic                  dp_gnt,
    output logic                  dp_rvalid,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy
);

    import bingo_pkg::*;

    localparam int CNT_W = $clog2(BURST_MAX + 1);

    arb_state_t state_q, state_d;
    logic [2:0] gnt_q, gnt_d;
    logic [2:0] req_vec;
    logic [2:0] exp_mask;
    logic [2:0] exp_cand;
    logic [1:0] win_all, win_exp;
    logic       own_req, other_pend;
    logic       dp_first;
    logic       burst_done;
    logic       cnt_clr, cnt_load, cnt_inc;

    assign req_vec    = {dp_req, gl_req, ld_req};
    assign own_req    = |(gnt_q & req_vec);
    assign other_pend = |(~gnt_q & req_vec);

`ifdef CARD_ARB_RR_EN
    logic rr_dp_first_q;

    // Remember whether gl or dp was served last; the last-served one loses the next tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rr_dp_first_q <= 1'b0;
        else if (cnt_load) begin
            if (gnt_d[GL])
                rr_dp_first_q <= 1'b1;
            else if (gnt_d[DP])
                rr_dp_first_q <= 1'b0;
        end
    end

    assign dp_first = rr_dp_first_q;
    assign exp_mask = ~gnt_q;
`else
    // Fixed priority: an expiring gl burst still beats dp, so gl stays a candidate.
    assign dp_first = 1'b0;
    assign exp_mask = gnt_q[GL] ? 3'b111 : ~gnt_q;
`endif

    assign exp_cand = req_vec & exp_mask;
    assign win_all  = pick_winner(req_vec[LD], req_vec[GL], req_vec[DP], dp_first);
    assign win_exp  = pick_winner(exp_cand[LD], exp_cand[GL], exp_cand[DP], dp_first);

    card_ram_arbiter_cnt #(
        .WIDTH (CNT_W),
        .MAX   (BURST_MAX)
    ) u_burst_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (cnt_clr),
        .load   (cnt_load),
        .inc    (cnt_inc),
        .at_max (burst_done)
    );

    // State and grant registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
        end
    end

    // Next-state: grant on any request, hand over gaplessly on drop or burst expiry.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        cnt_clr  = 1'b0;
        cnt_load = 1'b0;
        cnt_inc  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|req_vec) begin
                    state_d  = ST_HOLD;
                    gnt_d    = 3'b001 << win_all;
                    cnt_load = 1'b1;
                end
            end
            ST_HOLD: begin
                if (!own_req) begin
                    if (|req_vec) begin
                        gnt_d    = 3'b001 << win_all;
                        cnt_load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                        cnt_clr = 1'b1;
                    end
                end else if (burst_done && other_pend) begin
                    gnt_d    = 3'b001 << win_exp;
                    cnt_load = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                cnt_clr = 1'b1;
            end
        endcase
    end

    // RAM port follows the owner only while it is still requesting.
    always_comb begin
        ram_addr  = '0;
        ram_wdata = '0;
        ram_we    = 1'b0;
        if (gnt_q[LD] && ld_req) begin
            ram_addr  = ld_addr;
            ram_wdata = ld_wdata;
            ram_we    = 1'b1;
        end else if (gnt_q[GL] && gl_req) begin
            ram_addr  = gl_addr;
            ram_wdata = gl_wdata;
            ram_we    = gl_we;
        end else if (gnt_q[DP] && dp_req) begin
            ram_addr  = dp_addr;
        end
    end

    // Read-valid pulses track the one-cycle RAM latency, even after the grant moves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gl_rvalid <= 1'b0;
            dp_rvalid <= 1'b0;
        end else begin
            gl_rvalid <= gnt_q[GL] && gl_req && !gl_we;
            dp_rvalid <= gnt_q[DP] && dp_req;
        end
    end

    assign ld_gnt = gnt_q[LD];
    assign gl_gnt = gnt_q[GL];
    assign dp_gnt = gnt_q[DP];
    assign busy   = |gnt_q;
    assign rdata  = ram_rdata;

endmodule

// File: doc/card_ram_arbiter.md
CARD_RAM_ARBITER -- requirements
Module: card_ram_arbiter

Interface
REQ-001 Parameters SHALL be:
- DATA_WIDTH, default 8, card number width.
- ADDR_WIDTH, default 4, card RAM address width.
- BURST_MAX, default 4, maximum consecutive granted cycles per hold.
REQ-002 Ports SHALL be, one per line (name  direction  width  meaning):
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ld_req  in  1  loader request (write only).
- ld_addr  in  ADDR_WIDTH  loader address.
- ld_wdata  in  DATA_WIDTH  loader write data.
- ld_gnt  out  1  loader grant.
- gl_req  in  1  game-logic request.
- gl_we  in  1  game-logic write (delete) strobe.
- gl_addr  in  ADDR_WIDTH  game-logic address.
- gl_wdata  in  DATA_WIDTH  game-logic write data.
- gl_gnt  out  1  game-logic grant.
- gl_rvalid  out  1  game-logic read data valid.
- dp_req  in  1  display-scanner request (read only).
- dp_addr  in  ADDR_WIDTH  display address.
- dp_gnt  out  1  display grant.
- dp_rvalid  out  1  display read data valid.
- ram_addr  out  ADDR_WIDTH  card RAM address.
- ram_wdata  out  DATA_WIDTH  card RAM write data.
- ram_we  out  1  card RAM write enable.
- ram_rdata  in  DATA_WIDTH  card RAM synchronous read data, one-cycle latency.
- rdata  out  DATA_WIDTH  read data, equal to ram_rdata.
- busy  out  1  any grant active.

Function
REQ-003 The FSM SHALL have states IDLE and HOLD; at most one of ld_gnt, gl_gnt and dp_gnt SHALL be high in any cycle.
REQ-004 In IDLE, if any request is high, the arbiter SHALL pick a winner, raise its gnt on the next clock edge, and enter HOLD.
REQ-005 The loader SHALL always win when ld_req is high (fixed top priority).
REQ-006 Between gl and dp, the arbiter SHALL apply the priority policy selected per REQ-016.
REQ-007 Grants SHALL be registered; the RAM address, data and write enable SHALL be combinationally muxed from the current owner whenever its gnt and req are both high.
REQ-008 When no grant is active, or the owner has dropped req, ram_we SHALL be 0 and ram_addr and ram_wdata SHALL be 0.
REQ-009 In HOLD, a burst counter SHALL count granted cycles with req high, starting at 1.
REQ-010 The arbiter SHALL re-arbitrate at the next edge when any of these occur:
- the owner drops req (the grant drops in that same edge);
- the burst counter reaches BURST_MAX while another request is pending.
REQ-011 If BURST_MAX is reached with no other request pending, the grant SHALL continue and the counter SHALL saturate.
REQ-012 Re-arbitration SHALL be gapless: when another request is pending, the new grant SHALL rise at the same edge the old grant falls.
REQ-013 ram_we SHALL equal 1 only for the loader, or for game logic when gl_we is high; dp writes are impossible.
REQ-014 A read cycle (owner req high, write enable low) at cycle N SHALL produce that owner's rvalid pulse at N+1, with rdata valid at N+1; rvalid SHALL be produced even if the grant has moved by N+1.
REQ-015 The busy output SHALL be the OR of all three grants.

Configuration
REQ-016 With macro CARD_ARB_RR_EN defined, gl and dp SHALL alternate round-robin: the last-served of the two loses a tie. Without it, gl SHALL always beat dp.

Reset
REQ-017 rst SHALL asynchronously force:
- state IDLE;
- all gnt, rvalid and busy outputs to 0;
- burst counter to 0;
- round-robin pointer to favour gl.
REQ-018 Reset asserted mid-burst SHALL drop the grant immediately, and no rvalid SHALL follow.

Structure
REQ-019 State encodings and the requester index constants (LD=0, GL=1, DP=2) SHALL live in the shared package bingo_pkg.
REQ-020 The burst counter SHALL be instantiated as the existing codebase counter module; no other sub-module is used.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- gl_req=1 alone, gl_we=0, gl_addr=3 -> gl_gnt high at cycle 1; ram_addr=3; gl_rvalid at cycle 2 with rdata=RAM[3].
- ld_req and gl_req rise together -> ld_gnt wins; after BURST_MAX=4 cycles ld_gnt drops and gl_gnt rises at the same edge.
- Only gl requesting for 10 cycles -> grant holds all 10 cycles; counter saturates at 4.
- With CARD_ARB_RR_EN, gl and dp continuously requesting -> grants alternate every 4 cycles. Without the macro -> dp is never granted.
- gl holds with gl_we=1, addr=5, wdata=0 -> ram_we=1 for exactly the granted cycles; RAM[5] reads back 0.
- rst pulsed during a dp read burst -> dp_gnt=0 and busy=0 immediately; no dp_rvalid afterwards.
